// File: rtl/as_pack.sv
// Shared constants and types for the as_gpio_port GPIO peripheral.
// Register offsets, register index enum and default sizing.
package as_pack;

    localparam int nr_gpios        = 32;
    localparam int gpio_addr_width = 6;

    localparam logic [gpio_addr_width-1:0] GPIO_DATA_OUT = 6'h00;
    localparam logic [gpio_addr_width-1:0] GPIO_DIR      = 6'h08;
    localparam logic [gpio_addr_width-1:0] GPIO_DATA_IN  = 6'h10;
    localparam logic [gpio_addr_width-1:0] GPIO_IRQ_EN   = 6'h18;
    localparam logic [gpio_addr_width-1:0] GPIO_IRQ_PEND = 6'h20;

    typedef enum logic [2:0] {
        REG_DATA_OUT = 3'd0,
        REG_DIR      = 3'd1,
        REG_DATA_IN  = 3'd2,
        REG_IRQ_EN   = 3'd3,
        REG_IRQ_PEND = 3'd4
    } gpio_reg_e;

endpackage

// File: rtl/as_gpio_sync.sv
// Multi-flop input synchroniser with rising-edge detector.
// rise_o is high for one cycle when a bit of sync_o goes 0 -> 1.
module as_gpio_sync
    import as_pack::*;
#(
    parameter int W      = nr_gpios,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] sync_o,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] r_stg [STAGES];
    logic [W-1:0] r_prev;

    // Shift pins through the synchroniser chain; keep last value for edges
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < STAGES; k++) r_stg[k] <= '0;
            r_prev <= '0;
        end else begin
            r_stg[0] <= async_i;
            for (int k = 1; k < STAGES; k++) r_stg[k] <= r_stg[k-1];
            r_prev <= r_stg[STAGES-1];
        end
    end

    assign sync_o = r_stg[STAGES-1];
    assign rise_o = r_stg[STAGES-1] & ~r_prev;

endmodule

// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port: DATA_OUT, DIR, DATA_IN, and optional IRQ regs.
// IRQ_EN/IRQ_PEND, edge interrupts and irq_o need macro AS_GPIO_IRQ_EN.
module as_gpio_port
    import as_pack::*;
#(
    parameter int NR_GPIOS    = nr_gpios,
    parameter int DATA_W      = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       sel_i,
    input  logic                       we_i,
    input  logic                       re_i,
    input  logic [gpio_addr_width-1:0] addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/8-1:0]        be_i,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       rvalid_o,
    inout  wire  [NR_GPIOS-1:0]        gpio_io,
    output logic                       cs_o,
    output logic                       irq_o
);

    logic [2:0]          w_idx;
    logic                w_wr;
    logic                w_rd;
    logic                w_any_be;
    logic [DATA_W-1:0]   w_bmask;
    logic [NR_GPIOS-1:0] w_wmask;
    logic [NR_GPIOS-1:0] w_wdata;
    logic [NR_GPIOS-1:0] w_sync;
    logic [NR_GPIOS-1:0] w_rise;
    logic [NR_GPIOS-1:0] w_rsel;
    logic [NR_GPIOS-1:0] w_en_rd;
    logic [NR_GPIOS-1:0] w_pend_rd;
    logic                w_unused;

    logic [NR_GPIOS-1:0] r_dout;
    logic [NR_GPIOS-1:0] r_dir;
    logic                r_cs;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    assign w_idx    = addr_i[5:3];
    assign w_wr     = sel_i & we_i;
    assign w_rd     = sel_i & re_i & ~we_i;
    assign w_any_be = |be_i;
    assign w_wmask  = w_bmask[NR_GPIOS-1:0];
    assign w_wdata  = wdata_i[NR_GPIOS-1:0];
    assign w_unused = ^{addr_i[2:0], wdata_i, w_bmask};

    // Expand byte enables into a per-bit write mask
    always_comb begin
        w_bmask = '0;
        for (int k = 0; k < DATA_W; k++) w_bmask[k] = be_i[k/8];
    end

    as_gpio_sync #(
        .W      (NR_GPIOS),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .async_i (gpio_io),
        .sync_o  (w_sync),
        .rise_o  (w_rise)
    );

    for (genvar g = 0; g < NR_GPIOS; g++) begin : g_pin
        assign gpio_io[g] = r_dir[g] ? r_dout[g] : 1'bz;
    end

    // Output data / direction registers and the DATA_OUT commit pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dout <= '0;
            r_dir  <= '1;
            r_cs   <= 1'b0;
        end else begin
            r_cs <= w_wr && (w_idx == REG_DATA_OUT) && w_any_be;
            if (w_wr && (w_idx == REG_DATA_OUT))
                r_dout <= (r_dout & ~w_wmask) | (w_wdata & w_wmask);
            if (w_wr && (w_idx == REG_DIR))
                r_dir <= (r_dir & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

`ifdef AS_GPIO_IRQ_EN
    logic [NR_GPIOS-1:0] r_en;
    logic [NR_GPIOS-1:0] r_pend;
    logic                r_irq;
    logic [NR_GPIOS-1:0] w_set;
    logic [NR_GPIOS-1:0] w_clr;

    assign w_set = w_rise & ~r_dir;
    assign w_clr = (w_wr && (w_idx == REG_IRQ_PEND)) ?
                   (w_wdata & w_wmask) : '0;

    // Enable/pending state; a same-cycle edge beats a w1c clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_en   <= '0;
            r_pend <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && (w_idx == REG_IRQ_EN))
                r_en <= (r_en & ~w_wmask) | (w_wdata & w_wmask);
            r_pend <= (r_pend & ~w_clr) | w_set;
            r_irq  <= |(r_pend & r_en);
        end
    end

    assign irq_o     = r_irq;
    assign w_en_rd   = r_en;
    assign w_pend_rd = r_pend;
`else
    logic w_unused_rise;

    assign w_unused_rise = ^w_rise;
    assign irq_o         = 1'b0;
    assign w_en_rd       = '0;
    assign w_pend_rd     = '0;
`endif

    // Select the register addressed by the current read
    always_comb begin
        w_rsel = '0;
        case (w_idx)
            REG_DATA_OUT: w_rsel = r_dout;
            REG_DIR:      w_rsel = r_dir;
            REG_DATA_IN:  w_rsel = w_sync;
            REG_IRQ_EN:   w_rsel = w_en_rd;
            REG_IRQ_PEND: w_rsel = w_pend_rd;
            default:      w_rsel = '0;
        endcase
    end

    // Registered read response; rdata holds between reads
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= DATA_W'(w_rsel);
        end
    end

    assign rdata_o  = r_rdata;
    assign rvalid_o = r_rvalid;
    assign cs_o     = r_cs;

endmodule
